// File: rtl/aes_spi_ctrl.sv
// SPI-slave front end for an AES-128 core: shifts in key+plaintext, starts the core, shifts out ciphertext.
// Optional WAIT timeout (err flag, all-ones ciphertext) is built only when AES_TIMEOUT_EN is defined.
module aes_spi_ctrl #(
    parameter int KEY_W = 128,
    parameter int BLK_W = 128
`ifdef AES_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             mosi,
    input  logic             cs,
    output logic             miso,
    output logic [KEY_W-1:0] aes_key,
    output logic [BLK_W-1:0] aes_din,
    output logic             aes_start,
    input  logic             aes_done,
    input  logic [BLK_W-1:0] aes_dout,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam int FRAME_W = KEY_W + BLK_W;
    localparam logic [8:0] RX_LAST = 9'(FRAME_W - 1);
    localparam logic [8:0] TX_BITS = 9'(BLK_W);

    // state_dbg encoding: 0 IDLE, 1 RX, 2 START, 3 WAIT, 4 TX
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RX    = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        TX    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic sck_m, sck_q1, sck_q2;
    logic cs_m, cs_q1, cs_q2;
    logic mosi_m, mosi_s;
    logic sck_rise, cs_rise, cs_fall;

    logic [FRAME_W-1:0] rx_sr;
    logic [BLK_W-1:0]   tx_sr;
    logic [8:0]         bit_cnt;
    logic               timeout_hit;

    // sck and cs get one extra flop beyond the synchronizer pair so edges can be detected
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_m  <= 1'b0;
            sck_q1 <= 1'b0;
            sck_q2 <= 1'b0;
            cs_m   <= 1'b0;
            cs_q1  <= 1'b0;
            cs_q2  <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sck_m  <= sck;
            sck_q1 <= sck_m;
            sck_q2 <= sck_q1;
            cs_m   <= cs;
            cs_q1  <= cs_m;
            cs_q2  <= cs_q1;
            mosi_m <= mosi;
            mosi_s <= mosi_m;
        end
    end

    assign sck_rise = sck_q1 & ~sck_q2;
    assign cs_rise  = cs_q1 & ~cs_q2;
    assign cs_fall  = ~cs_q1 & cs_q2;

`ifdef AES_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wait_cnt;
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cs_rise) state_d = RX;
            RX:    if (sck_rise && bit_cnt == RX_LAST) state_d = START;
            START: state_d = WAIT;
            WAIT:  if (aes_done || timeout_hit) state_d = TX;
            TX:    state_d = TX;
            default: state_d = IDLE;
        endcase
        // A dropped frame select wins over everything else
        if (cs_fall) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr     <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            aes_key   <= '0;
            aes_din   <= '0;
            aes_start <= 1'b0;
`ifdef AES_TIMEOUT_EN
            wait_cnt  <= '0;
            err       <= 1'b0;
`endif
        end else begin
            aes_start <= 1'b0;
            case (state_q)
                IDLE: if (cs_rise) bit_cnt <= '0;
                RX: if (sck_rise) begin
                    rx_sr   <= {rx_sr[FRAME_W-2:0], mosi_s};
                    bit_cnt <= bit_cnt + 9'd1;
                end
                START: begin
                    aes_key   <= rx_sr[FRAME_W-1:BLK_W];
                    aes_din   <= rx_sr[BLK_W-1:0];
                    aes_start <= 1'b1;
`ifdef AES_TIMEOUT_EN
                    wait_cnt  <= '0;
                    err       <= 1'b0;
`endif
                end
                WAIT: begin
                    if (aes_done) begin
                        tx_sr   <= aes_dout;
                        bit_cnt <= '0;
                    end
`ifdef AES_TIMEOUT_EN
                    else if (timeout_hit) begin
                        tx_sr   <= '1;
                        err     <= 1'b1;
                        bit_cnt <= '0;
                    end
                    wait_cnt <= wait_cnt + 16'd1;
`endif
                end
                // Shifting stops after the last ciphertext bit so trailing edges change nothing
                TX: if (sck_rise && bit_cnt != TX_BITS) begin
                    tx_sr   <= {tx_sr[BLK_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 9'd1;
                end
                default: ;
            endcase
            if (cs_fall) bit_cnt <= '0;
        end
    end

    assign miso      = (state_q == TX) ? tx_sr[BLK_W-1] : 1'b0;
    assign busy      = (state_q == START) || (state_q == WAIT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Bench for aes_spi_ctrl: SPI master driver, AES core stub, start/ciphertext scoreboards.
// Timeout scenario runs only when AES_TIMEOUT_EN is defined (TIMEOUT_CYC set to 64).
module tb_aes_spi_ctrl;

    localparam int HALF = 5;
    localparam logic [2:0] S_IDLE = 3'd0, S_RX = 3'd1, S_TX = 3'd4;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk, rst, sck, mosi, cs, miso;
    logic [127:0] aes_key, aes_din, aes_dout;
    logic         aes_start, aes_done, busy, err;
    logic [2:0]   state_dbg;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int exp_start_cnt = 0;
    int stub_en = 1;
    int man_req = 0;
    int man_ack = 0;
    int busy_run = 0;
    int last_busy_len = 0;
    logic [3:0] tx_extra;

    logic [255:0] exp_start_q[$];
    logic [127:0] exp_ct_q[$];
    logic [127:0] got_q[$];

    aes_spi_ctrl #(
        .KEY_W(128),
        .BLK_W(128)
`ifdef AES_TIMEOUT_EN
        , .TIMEOUT_CYC(64)
`endif
    ) dut (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .cs(cs), .miso(miso),
        .aes_key(aes_key), .aes_din(aes_din), .aes_start(aes_start),
        .aes_done(aes_done), .aes_dout(aes_dout), .busy(busy), .err(err),
        .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // What the core returns: the known-answer vector, otherwise an arbitrary mix of key and plaintext
    function automatic logic [127:0] ref_ct(input logic [127:0] k, input logic [127:0] p);
        if (k == KAT_KEY && p == KAT_PT) return KAT_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5_5a5a_c3c3_3c3c_0f0f_f0f0_9696_6969;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // AES core stub: answers aes_start after ~10 cycles, or pulses aes_done on request
    initial begin
        int dly;
        logic [127:0] k, p;
        dly = 0; k = '0; p = '0;
        aes_done = 1'b0;
        aes_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            aes_done = 1'b0;
            if (man_req != man_ack) begin
                aes_done = 1'b1;
                aes_dout = {$urandom, $urandom, $urandom, $urandom};
                man_ack++;
            end else if (aes_start && stub_en != 0) begin
                k = aes_key;
                p = aes_din;
                dly = 10;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    aes_done = 1'b1;
                    aes_dout = ref_ct(k, p);
                end
            end
        end
    end

    // Start monitor: every aes_start must match the oldest completed load
    initial begin
        logic [255:0] e;
        forever begin
            @(negedge clk);
            if (!rst && aes_start) begin
                start_cnt++;
                if (exp_start_q.size() == 0) begin
                    chk("unexpected_start", {aes_key, aes_din}, '0);
                end else begin
                    e = exp_start_q.pop_front();
                    chk("start_key_din", {aes_key, aes_din}, e);
                end
            end
        end
    end

    // Ciphertext monitor: each word read back on miso is compared with the expected response
    initial begin
        logic [127:0] g;
        forever begin
            @(negedge clk);
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                if (exp_ct_q.size() == 0) chk("unexpected_ct", {128'd0, g}, '1);
                else chk("miso_ciphertext", {128'd0, g}, {128'd0, exp_ct_q.pop_front()});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic send_range(input logic [255:0] d, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mosi = d[i];
            tick(HALF);
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic read_tx(input int n);
        logic [127:0] w;
        logic [3:0] x;
        logic b;
        w = '0; x = '0;
        for (int i = 0; i < n; i++) begin
            mosi = 1'b0;
            tick(HALF);
            b = miso;
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
            if (i < 128) w = {w[126:0], b};
            else x = {x[2:0], b};
        end
        got_q.push_back(w);
        tx_extra = x;
    endtask

    task automatic wait_busy_low();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) chk("busy_fall_timeout", 256'(n), 256'd0);
    endtask

    // One complete frame; inject_at >= 0 pulses aes_done while still receiving
    task automatic run_frame(input logic [127:0] k, input logic [127:0] p,
                             input int tx_bits, input int inject_at);
        logic [255:0] d;
        d = {k, p};
        exp_start_q.push_back(d);
        exp_start_cnt++;
        exp_ct_q.push_back(stub_en != 0 ? ref_ct(k, p) : '1);
        cs = 1'b1;
        tick(4);
        if (inject_at >= 0) begin
            send_range(d, 255, 255 - inject_at);
            man_req++;
            tick(4);
            chk("done_in_rx_state", 256'(state_dbg), 256'(S_RX));
            chk("done_in_rx_miso", 256'(miso), 256'd0);
            send_range(d, 254 - inject_at, 0);
        end else begin
            send_range(d, 255, 0);
        end
        wait_busy_low();
        tick(4);
        read_tx(tx_bits);
        if (tx_bits > 128) begin
            tick(4);
            chk("tx_extra_zeros", 256'(tx_extra), 256'd0);
            chk("tx_holds_until_cs", 256'(state_dbg), 256'(S_TX));
        end
        cs = 1'b0;
        tick(6);
        chk("idle_after_frame", 256'(state_dbg), 256'(S_IDLE));
    endtask

    initial begin
        logic [127:0] rk, rp;
        logic [255:0] d;
        rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b0;
        tick(2);
        chk("reset_outs", {252'd0, miso, aes_start, busy, err}, '0);
        chk("reset_key_din", {aes_key, aes_din}, '0);
        chk("reset_state", 256'(state_dbg), 256'(S_IDLE));
        rst = 1'b0;
        tick(3);

        // cs low with no frame, then aes_done while idle
        tick(20);
        chk("idle_no_cs", 256'(state_dbg), 256'(S_IDLE));
        man_req++;
        tick(4);
        chk("done_in_idle_state", 256'(state_dbg), 256'(S_IDLE));
        chk("done_in_idle_miso", 256'(miso), 256'd0);

        // Known-answer frame
        run_frame(KAT_KEY, KAT_PT, 128, -1);
        chk("kat_key_held", {aes_key, aes_din}, {KAT_KEY, KAT_PT});

        // Aborted frame after 100 bits, then a good frame
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cs = 1'b1;
        tick(4);
        send_range(d, 255, 156);
        cs = 1'b0;
        tick(6);
        chk("abort_rx_idle", 256'(state_dbg), 256'(S_IDLE));
        run_frame(KAT_KEY, KAT_PT, 128, -1);

        // Random frames, one with aes_done injected during RX, one with 132 TX rises
        for (int i = 0; i < 3; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            run_frame(rk, rp, (i == 2) ? 132 : 128, (i == 1) ? int'($urandom_range(20, 200)) : -1);
        end

        // Abort in WAIT, then a late aes_done must be ignored
        stub_en = 0;
        rk = {$urandom, $urandom, $urandom, $urandom};
        rp = {$urandom, $urandom, $urandom, $urandom};
        exp_start_q.push_back({rk, rp});
        exp_start_cnt++;
        cs = 1'b1;
        tick(4);
        send_range({rk, rp}, 255, 0);
        tick(2);
        chk("wait_busy", 256'(busy), 256'd1);
        cs = 1'b0;
        tick(6);
        chk("abort_wait_idle", 256'(state_dbg), 256'(S_IDLE));
        man_req++;
        tick(4);
        chk("late_done_ignored", {253'd0, state_dbg}, 256'(S_IDLE));
        chk("late_done_outs", {254'd0, miso, busy}, '0);
        chk("abort_key_kept", {aes_key, aes_din}, {rk, rp});
        stub_en = 1;

`ifdef AES_TIMEOUT_EN
        stub_en = 0;
        rk = {$urandom, $urandom, $urandom, $urandom};
        run_frame(rk, KAT_PT, 128, -1);
        chk("timeout_busy_len", 256'(last_busy_len), 256'd65);
        chk("timeout_err_set", 256'(err), 256'd1);
        stub_en = 1;
        run_frame(KAT_KEY, KAT_PT, 128, -1);
        chk("timeout_err_cleared", 256'(err), 256'd0);
`else
        chk("err_tied_low", 256'(err), 256'd0);
`endif

        tick(10);
        chk("start_count", 256'(start_cnt), 256'(exp_start_cnt));
        chk("queues_drained", 256'(exp_start_q.size() + exp_ct_q.size() + got_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
